ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, LSB-first data,
// odd parity, stop, device ACK check, and a frame timeout. All outputs are registered.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2841,
    parameter int TIMEOUT_CYCLES = 568180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           r_state, w_state_next;
    logic             r_clk_meta, r_clk_sync, r_clk_prev;
    logic             r_data_meta, r_data_sync;
    logic [7:0]       r_byte, w_byte_next;
    logic             r_parity, w_parity_next;
    logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_next;
    logic [TO_W-1:0]  r_to_cnt, w_to_cnt_next;
    logic [3:0]       r_bit_cnt, w_bit_cnt_next;
    logic             r_nack, w_nack_next;
    logic             r_ready, w_ready_next;
    logic             r_done, w_done_next;
    logic             r_error, w_error_next;
    logic             r_clk_oe, w_clk_oe_next;
    logic             r_data_oe, w_data_oe_next;
    logic             w_fall;

    assign w_fall = r_clk_prev & ~r_clk_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the reset is asynchronous so the lines release immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_byte    <= '0;
            r_parity  <= 1'b0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_bit_cnt <= '0;
            r_nack    <= 1'b0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_byte    <= w_byte_next;
            r_parity  <= w_parity_next;
            r_inh_cnt <= w_inh_cnt_next;
            r_to_cnt  <= w_to_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_nack    <= w_nack_next;
            r_ready   <= w_ready_next;
            r_done    <= w_done_next;
            r_error   <= w_error_next;
            r_clk_oe  <= w_clk_oe_next;
            r_data_oe <= w_data_oe_next;
        end
    end

    // Output next-values are derived from the next state, so each registered
    // output lines up with the state register.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_state_next   = r_state;
        w_byte_next    = r_byte;
        w_parity_next  = r_parity;
        w_inh_cnt_next = r_inh_cnt;
        w_to_cnt_next  = r_to_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_nack_next    = r_nack;
        w_done_next    = 1'b0;
        w_error_next   = 1'b0;
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = r_data_oe;

        case (r_state)
            IDLE: begin
                w_data_oe_next = 1'b0;
                if (tx_valid && r_ready) begin
                    w_byte_next    = tx_data;
                    w_parity_next  = ~^tx_data;
                    w_inh_cnt_next = '0;
                    w_nack_next    = 1'b0;
                    w_clk_oe_next  = 1'b1;
                    w_state_next   = INHIBIT;
                end
            end
            INHIBIT: begin
                w_clk_oe_next  = 1'b1;
                w_data_oe_next = 1'b0;
                if (r_inh_cnt == INH_LAST) begin
                    w_data_oe_next = 1'b1;
                    w_state_next   = REQUEST;
                end else begin
                    w_inh_cnt_next = r_inh_cnt + 1'b1;
                end
            end
            REQUEST: begin
                w_bit_cnt_next = '0;
                w_to_cnt_next  = '0;
                w_state_next   = SEND;
            end
            SEND: begin
                if (w_fall) begin
                    w_bit_cnt_next = r_bit_cnt + 4'd1;
                    if (r_bit_cnt < 4'd8) begin
                        w_data_oe_next = ~r_byte[r_bit_cnt[2:0]];
                    end else if (r_bit_cnt == 4'd8) begin
                        w_data_oe_next = ~r_parity;
                    end else begin
                        w_data_oe_next = 1'b0;
                        w_state_next   = ACK;
                    end
                end
            end
            ACK: begin
                if (w_fall) begin
                    w_nack_next  = r_data_sync;
                    w_state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (r_clk_sync && r_data_sync) begin
                    w_done_next  = 1'b1;
                    w_error_next = r_nack;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // A silent or stuck device must not hold the host forever.
        if (r_state == SEND || r_state == ACK || r_state == WAIT_IDLE) begin
            if (r_to_cnt == TO_LAST) begin
                w_state_next   = IDLE;
                w_clk_oe_next  = 1'b0;
                w_data_oe_next = 1'b0;
                w_done_next    = 1'b1;
                w_error_next   = 1'b1;
            end else begin
                w_to_cnt_next = r_to_cnt + 1'b1;
            end
        end

        w_ready_next = (w_state_next == IDLE) && !w_done_next;
    end

    assign tx_ready    = r_ready;
    assign tx_done     = r_done;
    assign tx_error    = r_error;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device that clocks at 1/40 clk
// and records the ten bits it samples (8 data, parity, stop) on each rising clock.
module tb_ps2_host_tx;
    localparam int INH  = 10;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int         n_checks = 0;
    int         n_errors = 0;

    int         dev_mode = 0;        // 0 ACK, 1 NACK, 2 stall after edge 4
    logic       dev_enable = 1'b1;
    logic       dev_busy = 1'b0;
    int         dev_edges = 0;
    logic [9:0] dev_bits = '0;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Device: starts when it sees clock released with data low (request-to-send).
    initial begin : device
        forever begin
            @(negedge clk);
            if (dev_enable && rst_n && ps2_clk_line && !ps2_data_line) begin
                dev_busy  = 1'b1;
                dev_edges = 0;
                dev_bits  = '0;
                repeat (HALF) @(negedge clk);
                for (int k = 0; k < 11; k++) begin
                    if (dev_mode == 2 && k == 4) begin
                        dev_enable = 1'b0;
                        break;
                    end
                    if (k == 10) begin
                        if (dev_mode != 1) dev_data_low = 1'b1;
                        repeat (5) @(negedge clk);
                    end
                    dev_clk_low = 1'b1;
                    dev_edges++;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (k < 10) dev_bits[k] = ps2_data_line;
                    repeat (HALF) @(negedge clk);
                end
                dev_data_low = 1'b0;
                dev_busy     = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the first negedge showing the inhibit (clock pulled low).
    task automatic start_frame(input logic [7:0] b, input logic hold);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!ps2_clk_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(ps2_clk_oe), 1);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic check_request();
        int n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(n), INH);
        check("request_oe", 32'({ps2_clk_oe, ps2_data_oe}), 3);
        @(negedge clk);
        check("release_oe", 32'({ps2_clk_oe, ps2_data_oe}), 1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!tx_done && cycles < 5000) begin
            @(negedge clk);
            cycles++;
        end
        check("done_seen", 32'(tx_done), 1);
    endtask

    task automatic finish_frame(input string tag, input logic [9:0] exp_bits, input logic exp_err);
        int cyc;
        wait_done(cyc);
        check({tag, "_err"}, 32'(tx_error), 32'(exp_err));
        check({tag, "_bits"}, 32'(dev_bits), 32'(exp_bits));
        @(negedge clk);
        check({tag, "_pulse"}, 32'({tx_done, tx_error}), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        int n;
        int cnt;

        repeat (3) @(negedge clk);
        check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("rst_ready", 32'(tx_ready), 0);
        check("rst_done", 32'({tx_done, tx_error}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(tx_ready), 1);

        // 0xED: data 1,0,1,1,0,1,1,1, parity 1, stop 1
        start_frame(8'hED, 1'b0);
        check_request();
        finish_frame("ed", 10'h3ED, 1'b0);

        // 0x00 then 0x01 with tx_valid held across the first frame
        start_frame(8'h00, 1'b1);
        tx_data = 8'h01;
        check_request();
        wait_done(cyc);
        check("b2b0_bits", 32'(dev_bits), 32'h300);
        check("b2b0_err", 32'(tx_error), 0);
        check("b2b0_no_early", 32'(ps2_clk_oe), 0);
        start_frame(8'h01, 1'b0);
        check_request();
        finish_frame("b2b1", 10'h201, 1'b0);

        // Device leaves data high at the ACK edge
        dev_mode = 1;
        start_frame(8'h55, 1'b0);
        check_request();
        wait_done(cyc);
        check("nack_err", 32'(tx_error), 1);
        check("nack_lines_idle", 32'({ps2_clk_line, ps2_data_line}), 3);
        check("nack_bits", 32'(dev_bits), 32'h355);
        @(negedge clk);
        check("nack_pulse", 32'({tx_done, tx_error}), 0);

        // Device stalls after edge 4
        dev_mode = 2;
        start_frame(8'hED, 1'b0);
        check_request();
        wait_done(cyc);
        check("timeout_cycles", 32'(cyc), TO);
        check("timeout_err", 32'(tx_error), 1);
        check("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("timeout_bits", 32'(dev_bits[3:0]), 32'hD);
        @(negedge clk);
        check("timeout_ready", 32'(tx_ready), 1);
        dev_mode   = 0;
        dev_enable = 1'b1;

        // Reset during bit 5 (data bit 4 of 0xED is 0, so data_oe is 1)
        @(negedge clk);
        start_frame(8'hED, 1'b0);
        check_request();
        n = 0;
        while (dev_edges < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        check("bit5_data_oe", 32'(ps2_data_oe), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("rst_mid_done", 32'(tx_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        n = 0;
        while (dev_busy && n < 1000) begin
            @(negedge clk);
            n++;
            if (tx_done) cnt++;
        end
        check("rst_no_done", 32'(cnt), 0);
        check("rst_dev_idle", 32'(dev_busy), 0);
        start_frame(8'hF4, 1'b0);
        check_request();
        finish_frame("f4", 10'h2F4, 1'b0);

        // New request while the frame is in flight must not disturb it
        start_frame(8'hA5, 1'b0);
        check_request();
        repeat (100) @(negedge clk);
        check("send_ready_low", 32'(tx_ready), 0);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        repeat (20) @(negedge clk);
        tx_valid = 1'b0;
        finish_frame("a5", 10'h3A5, 1'b0);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (ps2_clk_oe) cnt++;
        end
        check("no_second_frame", 32'(cnt), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
